// File: rtl/fury_drive_pkg.sv
// Shared drive definitions: steering code constants, sequencer state
// encodings, default duty levels and code classification helpers.
// Also used by the steering decode block, so keep the codes stable.
package fury_drive_pkg;

    localparam logic [3:0] CMD_PROCEED  = 4'b0000;
    localparam logic [3:0] CMD_VEER_R   = 4'b1001;
    localparam logic [3:0] CMD_HARD_R   = 4'b1010;
    localparam logic [3:0] CMD_NINETY_R = 4'b1011;
    localparam logic [3:0] CMD_VEER_L   = 4'b0101;
    localparam logic [3:0] CMD_HARD_L   = 4'b0110;
    localparam logic [3:0] CMD_NINETY_L = 4'b0111;
    localparam logic [3:0] CMD_STOP     = 4'b1111;

    localparam logic [7:0] FULL_DUTY_DEF  = 8'd200;
    localparam logic [7:0] VEER_DUTY_DEF  = 8'd120;
    localparam logic [7:0] PIVOT_DUTY_DEF = 8'd160;

    localparam int TIMER_W = 28;

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_BRAKE   = 3'd2,
        ST_PIVOT   = 3'd3,
        ST_SETTLE  = 3'd4
    } state_e;

    // Anything that is not one of the seven motion codes behaves as STOP.
    function automatic logic is_stop_code(input logic [3:0] code);
        logic stop;
        case (code)
            CMD_PROCEED, CMD_VEER_R, CMD_HARD_R, CMD_NINETY_R,
            CMD_VEER_L, CMD_HARD_L, CMD_NINETY_L: stop = 1'b0;
            default:                              stop = 1'b1;
        endcase
        return stop;
    endfunction

    function automatic logic is_ninety_code(input logic [3:0] code);
        return (code == CMD_NINETY_R) || (code == CMD_NINETY_L);
    endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Steering-in / motor-command-out bundle of the turn sequencer.
//   dir_cmd, dir_valid, direction, estop : steering side -> sequencer
//   left/right_duty, left/right_fwd      : sequencer -> PWM generators
//   busy, turn_done                      : sequencer status
// master = steering/supervisor side, slave = sequencer.
interface turn_sequencer_if;
    logic [3:0] dir_cmd;
    logic       dir_valid;
    logic       direction;
    logic       estop;
    logic [7:0] left_duty;
    logic [7:0] right_duty;
    logic       left_fwd;
    logic       right_fwd;
    logic       busy;
    logic       turn_done;

    modport master (
        output dir_cmd, dir_valid, direction, estop,
        input  left_duty, right_duty, left_fwd, right_fwd, busy, turn_done
    );

    modport slave (
        input  dir_cmd, dir_valid, direction, estop,
        output left_duty, right_duty, left_fwd, right_fwd, busy, turn_done
    );
endinterface

// File: rtl/tick_timer.sv
// Dwell timer shared by BRAKE, PIVOT and SETTLE.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (takes priority over counting)
//   load_val   : ticks-1 for the dwell being started
//   done       : count has reached zero
// Counts down to zero and parks there.
module tick_timer
    import fury_drive_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               done
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: turns steering codes into per-wheel duty/polarity,
// runs timed pivots for 90-degree turns and brakes before reversing.
//   clk, rst_n : 25 MHz system clock, async active-low reset
//   bus        : turn_sequencer_if.slave (steering in, motor commands out)
// All outputs are registered; a strobe shows up on the duties one clock later.
//
// state   | meaning
// STOPPED | duties 0, polarity follows direction, waits for a motion code
// DRIVE   | duties from the last steering code, polarity = cur_dir
// BRAKE   | duties 0, polarity held, then flip to new direction
// PIVOT   | spin in place at pivot duty, inner wheel reversed
// SETTLE  | duties 0 after pivot, then DRIVE with PROCEED + turn_done
module turn_sequencer
    import fury_drive_pkg::*;
#(
    parameter logic [7:0]         FULL_DUTY    = FULL_DUTY_DEF,
    parameter logic [7:0]         VEER_DUTY    = VEER_DUTY_DEF,
    parameter logic [7:0]         PIVOT_DUTY   = PIVOT_DUTY_DEF,
    parameter logic [TIMER_W-1:0] PIVOT_TICKS  = 28'd25_000_000,
    parameter logic [TIMER_W-1:0] SETTLE_TICKS = 28'd2_500_000,
    parameter logic [TIMER_W-1:0] BRAKE_TICKS  = 28'd5_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    turn_sequencer_if.slave  bus
);

    state_e     state_q, state_d;
    logic       cur_dir_q, cur_dir_d;
    logic [3:0] pend_cmd_q, pend_cmd_d;
    logic       pend_vld_q, pend_vld_d;
    logic [7:0] left_duty_q, left_duty_d;
    logic [7:0] right_duty_q, right_duty_d;
    logic       left_fwd_q, left_fwd_d;
    logic       right_fwd_q, right_fwd_d;
    logic       busy_q, busy_d;
    logic       turn_done_q, turn_done_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_done;

    // Launch request: a command to start from this cycle, with the
    // polarity it should drive at.
    logic       go;
    logic [3:0] go_cmd;
    logic       go_dir;

    tick_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // {left, right} duty for the non-pivot motion codes.
    function automatic logic [15:0] drive_duty(input logic [3:0] code);
        logic [15:0] d;
        case (code)
            CMD_PROCEED: d = {FULL_DUTY, FULL_DUTY};
            CMD_VEER_R:  d = {FULL_DUTY, VEER_DUTY};
            CMD_HARD_R:  d = {FULL_DUTY, 8'd0};
            CMD_VEER_L:  d = {VEER_DUTY, FULL_DUTY};
            CMD_HARD_L:  d = {8'd0, FULL_DUTY};
            default:     d = 16'd0;
        endcase
        return d;
    endfunction

    always_comb begin
        state_d      = state_q;
        cur_dir_d    = cur_dir_q;
        pend_cmd_d   = pend_cmd_q;
        pend_vld_d   = pend_vld_q;
        left_duty_d  = left_duty_q;
        right_duty_d = right_duty_q;
        left_fwd_d   = left_fwd_q;
        right_fwd_d  = right_fwd_q;
        busy_d       = busy_q;
        turn_done_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        go           = 1'b0;
        go_cmd       = CMD_STOP;
        go_dir       = cur_dir_q;

        if (bus.estop) begin
            state_d      = ST_STOPPED;
            pend_cmd_d   = CMD_STOP;
            pend_vld_d   = 1'b0;
            left_duty_d  = 8'd0;
            right_duty_d = 8'd0;
            left_fwd_d   = cur_dir_q;
            right_fwd_d  = cur_dir_q;
            busy_d       = 1'b0;
            tmr_load     = 1'b1;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    // Wheels are idle, so polarity may track direction freely.
                    cur_dir_d   = bus.direction;
                    left_fwd_d  = bus.direction;
                    right_fwd_d = bus.direction;
                    if (bus.dir_valid && !is_stop_code(bus.dir_cmd)) begin
                        go     = 1'b1;
                        go_cmd = bus.dir_cmd;
                        go_dir = bus.direction;
                    end
                end
                ST_DRIVE: begin
                    if (bus.direction != cur_dir_q) begin
                        state_d      = ST_BRAKE;
                        left_duty_d  = 8'd0;
                        right_duty_d = 8'd0;
                        busy_d       = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_val      = BRAKE_TICKS - 1'b1;
                        pend_vld_d   = bus.dir_valid;
                        pend_cmd_d   = bus.dir_cmd;
                    end else if (bus.dir_valid) begin
                        go     = 1'b1;
                        go_cmd = bus.dir_cmd;
                    end
                end
                ST_BRAKE: begin
                    if (bus.dir_valid) begin
                        pend_vld_d = 1'b1;
                        pend_cmd_d = bus.dir_cmd;
                    end
                    if (tmr_done) begin
                        cur_dir_d = bus.direction;
                        go        = 1'b1;
                        go_dir    = bus.direction;
                        // A strobe on the exit cycle is the newest request.
                        if (bus.dir_valid) begin
                            go_cmd = bus.dir_cmd;
                        end else if (pend_vld_q) begin
                            go_cmd = pend_cmd_q;
                        end else begin
                            go_cmd = CMD_PROCEED;
                        end
                    end
                end
                ST_PIVOT: begin
                    if (bus.dir_valid && is_stop_code(bus.dir_cmd)) begin
                        go = 1'b1;
                    end else if (tmr_done) begin
                        state_d      = ST_SETTLE;
                        left_duty_d  = 8'd0;
                        right_duty_d = 8'd0;
                        // Restore travel polarity while the wheels are at zero.
                        left_fwd_d   = cur_dir_q;
                        right_fwd_d  = cur_dir_q;
                        tmr_load     = 1'b1;
                        tmr_val      = SETTLE_TICKS - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (bus.dir_valid && is_stop_code(bus.dir_cmd)) begin
                        go = 1'b1;
                    end else if (tmr_done) begin
                        go          = 1'b1;
                        go_cmd      = CMD_PROCEED;
                        turn_done_d = 1'b1;
                    end
                end
                default: begin
                    go = 1'b1;
                end
            endcase

            if (go) begin
                pend_vld_d = 1'b0;
                if (is_stop_code(go_cmd)) begin
                    state_d      = ST_STOPPED;
                    pend_cmd_d   = CMD_STOP;
                    left_duty_d  = 8'd0;
                    right_duty_d = 8'd0;
                    left_fwd_d   = go_dir;
                    right_fwd_d  = go_dir;
                    busy_d       = 1'b0;
                    tmr_load     = 1'b1;
                end else if (is_ninety_code(go_cmd)) begin
                    // Pivot polarity is absolute: the outer wheel pushes forwards.
                    state_d      = ST_PIVOT;
                    left_duty_d  = PIVOT_DUTY;
                    right_duty_d = PIVOT_DUTY;
                    left_fwd_d   = (go_cmd == CMD_NINETY_R);
                    right_fwd_d  = (go_cmd == CMD_NINETY_L);
                    busy_d       = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_val      = PIVOT_TICKS - 1'b1;
                end else begin
                    state_d                     = ST_DRIVE;
                    {left_duty_d, right_duty_d} = drive_duty(go_cmd);
                    left_fwd_d                  = go_dir;
                    right_fwd_d                 = go_dir;
                    busy_d                      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_STOPPED;
            cur_dir_q    <= 1'b1;
            pend_cmd_q   <= CMD_STOP;
            pend_vld_q   <= 1'b0;
            left_duty_q  <= 8'd0;
            right_duty_q <= 8'd0;
            left_fwd_q   <= 1'b1;
            right_fwd_q  <= 1'b1;
            busy_q       <= 1'b0;
            turn_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_dir_q    <= cur_dir_d;
            pend_cmd_q   <= pend_cmd_d;
            pend_vld_q   <= pend_vld_d;
            left_duty_q  <= left_duty_d;
            right_duty_q <= right_duty_d;
            left_fwd_q   <= left_fwd_d;
            right_fwd_q  <= right_fwd_d;
            busy_q       <= busy_d;
            turn_done_q  <= turn_done_d;
        end
    end

    assign bus.left_duty  = left_duty_q;
    assign bus.right_duty = right_duty_q;
    assign bus.left_fwd   = left_fwd_q;
    assign bus.right_fwd  = right_fwd_q;
    assign bus.busy       = busy_q;
    assign bus.turn_done  = turn_done_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with short dwell times
// (pivot 10, settle 4, brake 6 clocks). Expected output words are queued
// as each step is driven and checked one clock later.
module tb_turn_sequencer;
    import fury_drive_pkg::*;

    typedef struct {
        string       tag;
        logic [19:0] val;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    turn_sequencer_if bus ();

    turn_sequencer #(
        .PIVOT_TICKS  (28'd10),
        .SETTLE_TICKS (28'd4),
        .BRAKE_TICKS  (28'd6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Output word: {left_duty, right_duty, left_fwd, right_fwd, busy, turn_done}
    function automatic logic [19:0] pk(input logic [7:0] l, input logic [7:0] r,
                                       input logic lf, input logic rf,
                                       input logic b, input logic td);
        return {l, r, lf, rf, b, td};
    endfunction

    task automatic check_now();
        exp_t        e;
        logic [19:0] got;
        if (sb.size() == 0) return;
        e   = sb.pop_front();
        got = {bus.left_duty, bus.right_duty, bus.left_fwd, bus.right_fwd,
               bus.busy, bus.turn_done};
        vectors++;
        assert (got === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed L=%0d R=%0d fwd/busy/done=%b expected L=%0d R=%0d fwd/busy/done=%b",
                   e.tag, got[19:12], got[11:4], got[3:0],
                   e.val[19:12], e.val[11:4], e.val[3:0]);
        end
    endtask

    task automatic expect_now(input string tag, input logic [19:0] v);
        sb.push_back('{tag: tag, val: v});
        check_now();
    endtask

    task automatic cyc(input string tag, input logic [19:0] v);
        sb.push_back('{tag: tag, val: v});
        @(posedge clk);
        #1;
        check_now();
        bus.dir_valid = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] cmd);
        bus.dir_cmd   = cmd;
        bus.dir_valid = 1'b1;
    endtask

    localparam logic [19:0] RST_VAL = 20'h00_00C;   // 0/0, fwd 11, idle

    initial begin
        bus.dir_cmd   = CMD_STOP;
        bus.dir_valid = 1'b0;
        bus.direction = 1'b1;
        bus.estop     = 1'b0;

        #1 rst_n = 1'b0;
        #2 expect_now("reset", RST_VAL);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("idle", RST_VAL);

        strobe(CMD_PROCEED);
        cyc("proceed", pk(8'd200, 8'd200, 1, 1, 0, 0));
        cyc("proceed_hold", pk(8'd200, 8'd200, 1, 1, 0, 0));

        strobe(CMD_VEER_R);
        cyc("veer_r", pk(8'd200, 8'd120, 1, 1, 0, 0));
        strobe(CMD_HARD_L);
        cyc("hard_l", pk(8'd0, 8'd200, 1, 1, 0, 0));

        strobe(CMD_NINETY_L);
        for (int i = 0; i < 10; i++) cyc("pivot_l", pk(8'd160, 8'd160, 0, 1, 1, 0));
        for (int i = 0; i < 4; i++)  cyc("settle", pk(8'd0, 8'd0, 1, 1, 1, 0));
        cyc("turn_done", pk(8'd200, 8'd200, 1, 1, 0, 1));
        cyc("post_turn", pk(8'd200, 8'd200, 1, 1, 0, 0));

        bus.direction = 1'b0;
        strobe(CMD_VEER_L);
        for (int i = 0; i < 6; i++) cyc("brake", pk(8'd0, 8'd0, 1, 1, 1, 0));
        cyc("after_brake", pk(8'd120, 8'd200, 0, 0, 0, 0));
        cyc("after_brake_hold", pk(8'd120, 8'd200, 0, 0, 0, 0));

        strobe(CMD_NINETY_R);
        cyc("pivot_r1", pk(8'd160, 8'd160, 1, 0, 1, 0));
        cyc("pivot_r2", pk(8'd160, 8'd160, 1, 0, 1, 0));
        cyc("pivot_r3", pk(8'd160, 8'd160, 1, 0, 1, 0));
        bus.estop = 1'b1;
        cyc("estop", pk(8'd0, 8'd0, 0, 0, 0, 0));
        strobe(CMD_PROCEED);
        cyc("estop_block", pk(8'd0, 8'd0, 0, 0, 0, 0));
        cyc("estop_hold", pk(8'd0, 8'd0, 0, 0, 0, 0));
        bus.estop = 1'b0;
        cyc("estop_release", pk(8'd0, 8'd0, 0, 0, 0, 0));

        strobe(CMD_PROCEED);
        cyc("proceed_back", pk(8'd200, 8'd200, 0, 0, 0, 0));
        strobe(4'b1100);
        cyc("reserved_stop", pk(8'd0, 8'd0, 0, 0, 0, 0));
        cyc("reserved_hold", pk(8'd0, 8'd0, 0, 0, 0, 0));

        strobe(CMD_PROCEED);
        cyc("proceed_back2", pk(8'd200, 8'd200, 0, 0, 0, 0));
        bus.direction = 1'b1;
        cyc("brake2_a", pk(8'd0, 8'd0, 0, 0, 1, 0));
        cyc("brake2_b", pk(8'd0, 8'd0, 0, 0, 1, 0));
        rst_n = 1'b0;
        #2 expect_now("reset_mid_brake", RST_VAL);
        cyc("reset_held", RST_VAL);
        rst_n = 1'b1;
        cyc("reset_release", RST_VAL);

        strobe(CMD_NINETY_R);
        cyc("pivot_from_stop", pk(8'd160, 8'd160, 1, 0, 1, 0));
        strobe(CMD_VEER_R);
        cyc("pivot_ignore_veer", pk(8'd160, 8'd160, 1, 0, 1, 0));
        strobe(CMD_STOP);
        cyc("pivot_stop", pk(8'd0, 8'd0, 1, 1, 0, 0));
        cyc("pivot_stop_hold", pk(8'd0, 8'd0, 1, 1, 0, 0));

        strobe(CMD_HARD_R);
        cyc("hard_r_from_stop", pk(8'd200, 8'd0, 1, 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
